// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline hazard/forwarding controller
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - ALU operand forwarding select for one EX-stage source
module forward_sel
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] idex_rs_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  exmem_reg_write_i,
    input  logic                  exmem_mem_read_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  memwb_reg_write_i,
    output fwd_sel_t              fwd_o
);

    logic hit_exmem;
    logic hit_memwb;

    // A load in MEM has no data yet, so it must not win over MEM/WB.
    assign hit_exmem = exmem_reg_write_i && !exmem_mem_read_i
                    && (exmem_rd_i != '0) && (exmem_rd_i == idex_rs_i);
    assign hit_memwb = memwb_reg_write_i
                    && (memwb_rd_i != '0) && (memwb_rd_i == idex_rs_i);

    always_comb begin
        fwd_o = FWD_RF;
        if (hit_exmem) begin
            fwd_o = FWD_EXMEM;
        end else if (hit_memwb) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall FSM, flush/freeze priority, forwarding and stall counter
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] idex_rs1,
    input  logic [REG_ADDR_W-1:0] idex_rs2,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_mem_read,
    input  logic                  idex_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic                  exmem_mem_read,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic                  branch_taken,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  exmem_hold,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic       MULTI_CYCLE = (LOAD_LATENCY > 1);
    localparam logic [2:0] CNT_INIT    = 3'(LOAD_LATENCY - 1);

    hz_state_t        state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic     lu, freeze, flush, lu_stall;
    fwd_sel_t fwd_a_raw, fwd_b_raw;

    // idex_reg_write does not participate: a load always writes, and x0 is filtered by rd.
    assign lu = idex_mem_read && (idex_rd != '0)
             && ((id_rs1_used && (idex_rd == id_rs1)) || (id_rs2_used && (idex_rd == id_rs2)));
    assign freeze   = dmem_busy;
    assign flush    = branch_taken && !dmem_busy;
    assign lu_stall = (state_q == LD_STALL) || lu;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
        end else if (flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign stall = ~pc_write | exmem_hold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (freeze) begin
            state_d = state_q;
        end else if (flush) begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (state_q == RUN) begin
            if (lu && MULTI_CYCLE) begin
                state_d = LD_STALL;
                cnt_d   = CNT_INIT;
            end
        end else if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end else begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            cnt_q          <= 3'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .idex_rs_i         (idex_rs1),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_mem_read_i  (exmem_mem_read),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .fwd_o             (fwd_a_raw)
    );

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .idex_rs_i         (idex_rs2),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_mem_read_i  (exmem_mem_read),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .fwd_o             (fwd_b_raw)
    );

    assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
    assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench: LOAD_LATENCY=1 and LOAD_LATENCY=3/CNT_W=4 instances on shared inputs
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic       id_rs1_used, id_rs2_used, idex_mem_read, idex_reg_write;
    logic       exmem_reg_write, exmem_mem_read, memwb_reg_write, branch_taken, dmem_busy;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_stall;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_stall_cycles;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_exmem_hold, b_stall;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [3:0]  b_stall_cycles;

    int total = 0;
    int bad   = 0;
    int rem_a, rem_b, cnt_a, cnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .exmem_hold(a_exmem_hold),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall(a_stall), .stall_cycles(a_stall_cycles)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .exmem_hold(b_exmem_hold),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall(b_stall), .stall_cycles(b_stall_cycles)
    );

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_mem_read = 0; idex_reg_write = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_mem_read = 0;
        memwb_rd = 0; memwb_reg_write = 0; branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        idex_mem_read = 1; idex_reg_write = 1; idex_rd = r;
        id_rs1 = r; id_rs1_used = 1;
    endtask

    // Reference model: a count of stall cycles still owed by the current load, plus the spec's priority rules.
    function automatic bit lu_m();
        return idex_mem_read && (idex_rd != 0)
            && ((id_rs1_used && idex_rd == id_rs1) || (id_rs2_used && idex_rd == id_rs2));
    endfunction

    // Returns {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, stall}.
    function automatic logic [5:0] model_ctl(input int rem);
        logic pc, ifw, fl, bub, hold;
        pc = 1; ifw = 1; fl = 0; bub = 0; hold = 0;
        if (rst_n) begin
            if (dmem_busy) begin
                pc = 0; ifw = 0; hold = 1;
            end else if (branch_taken) begin
                fl = 1; bub = 1;
            end else if (rem > 0 || lu_m()) begin
                pc = 0; ifw = 0; bub = 1;
            end
        end
        return {pc, ifw, fl, bub, hold, (!pc) | hold};
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs && !exmem_mem_read) return 2'b10;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_next(input int ll, input int cmax, input bit st, inout int rem, inout int cnt);
        if (!rst_n) begin
            rem = 0; cnt = 0;
        end else begin
            if (st && cnt < cmax) cnt++;
            if (dmem_busy) rem = rem;
            else if (branch_taken) rem = 0;
            else if (rem > 0) rem--;
            else if (lu_m()) rem = ll - 1;
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0; dmem_busy = 1; branch_taken = 1; set_load_use(5'd3);
        exmem_rd = 3; exmem_reg_write = 1; idex_rs1 = 3;
        next_cycle();
        @(negedge clk);
        total++; if ({a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_stall} !== 6'b110000) begin
            bad++; $display("FAIL reset_ctl_a got=%b want=110000", {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_stall});
        end
        total++; if (b_exmem_hold !== 1'b0 || b_pc_write !== 1'b1) begin
            bad++; $display("FAIL reset_ctl_b hold=%b pc_write=%b want hold=0 pc_write=1", b_exmem_hold, b_pc_write);
        end
        total++; if (a_fwd_a !== 2'b00) begin
            bad++; $display("FAIL reset_fwd got=%b want=00", a_fwd_a);
        end
        next_cycle();
        set_idle(); rst_n = 1;
        @(negedge clk);
        total++; if (a_stall_cycles !== 16'd0 || b_stall_cycles !== 4'd0 || a_pc_write !== 1'b1) begin
            bad++; $display("FAIL reset_after cnt_a=%0d cnt_b=%0d pc_write=%b want 0 0 1", a_stall_cycles, b_stall_cycles, a_pc_write);
        end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        next_cycle(); set_load_use(5'd5);
        @(negedge clk);
        total++; if (a_pc_write !== 1'b0 || a_idex_bubble !== 1'b1 || a_ifid_write !== 1'b0) begin
            bad++; $display("FAIL lu1_stall pc_write=%b bubble=%b ifid_write=%b want 0 1 0", a_pc_write, a_idex_bubble, a_ifid_write);
        end
        next_cycle(); set_idle();
        @(negedge clk);
        total++; if (a_pc_write !== 1'b1 || a_stall_cycles !== 16'd1) begin
            bad++; $display("FAIL lu1_release pc_write=%b cnt=%0d want 1 1", a_pc_write, a_stall_cycles);
        end
    endtask

    task automatic test_load_use_lat3_freeze();
        logic [4:0] busy_pat = 5'b00010;
        logic [4:0] pc_exp   = 5'b10000;
        logic [4:0] hold_exp = 5'b00010;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle(); set_idle();
            if (i == 0) set_load_use(5'd5);
            dmem_busy = busy_pat[i];
            @(negedge clk);
            total++; if (b_pc_write !== pc_exp[i] || b_exmem_hold !== hold_exp[i]) begin
                bad++; $display("FAIL lu3_freeze_c%0d pc_write=%b hold=%b want %b %b", i, b_pc_write, b_exmem_hold, pc_exp[i], hold_exp[i]);
            end
        end
        total++; if (b_stall_cycles !== 4'd4) begin
            bad++; $display("FAIL lu3_freeze_cnt got=%0d want=4", b_stall_cycles);
        end
    endtask

    task automatic test_x0();
        do_reset();
        next_cycle();
        idex_mem_read = 1; idex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 1; id_rs2_used = 1;
        exmem_rd = 0; exmem_reg_write = 1; idex_rs1 = 0;
        @(negedge clk);
        total++; if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1) begin
            bad++; $display("FAIL x0_no_stall pc_a=%b pc_b=%b want 1 1", a_pc_write, b_pc_write);
        end
        total++; if (a_fwd_a !== 2'b00) begin
            bad++; $display("FAIL x0_no_fwd got=%b want=00", a_fwd_a);
        end
    endtask

    task automatic test_forward();
        do_reset();
        next_cycle();
        exmem_rd = 7; exmem_reg_write = 1; memwb_rd = 7; memwb_reg_write = 1;
        idex_rs1 = 7; idex_rs2 = 7;
        @(negedge clk);
        total++; if (a_fwd_a !== 2'b10 || b_fwd_b !== 2'b10) begin
            bad++; $display("FAIL fwd_exmem a=%b b=%b want 10 10", a_fwd_a, b_fwd_b);
        end
        next_cycle(); exmem_mem_read = 1;
        @(negedge clk);
        total++; if (a_fwd_a !== 2'b01 || a_fwd_b !== 2'b01) begin
            bad++; $display("FAIL fwd_memwb a=%b b=%b want 01 01", a_fwd_a, a_fwd_b);
        end
        next_cycle(); memwb_reg_write = 0; idex_rs2 = 3;
        @(negedge clk);
        total++; if (a_fwd_a !== 2'b00 || a_fwd_b !== 2'b00) begin
            bad++; $display("FAIL fwd_none a=%b b=%b want 00 00", a_fwd_a, a_fwd_b);
        end
    endtask

    task automatic test_branch_flush();
        int stalls = 0;
        do_reset();
        next_cycle(); set_load_use(5'd9); branch_taken = 1;
        @(negedge clk);
        total++; if (b_ifid_flush !== 1'b1 || b_pc_write !== 1'b1 || b_idex_bubble !== 1'b1) begin
            bad++; $display("FAIL flush_first flush=%b pc_write=%b bubble=%b want 1 1 1", b_ifid_flush, b_pc_write, b_idex_bubble);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_idle();
            @(negedge clk);
            if (b_pc_write !== 1'b1) stalls++;
        end
        total++; if (stalls != 0 || b_stall_cycles !== 4'd0) begin
            bad++; $display("FAIL flush_dropped stalls=%0d cnt=%0d want 0 0", stalls, b_stall_cycles);
        end
        next_cycle(); set_load_use(5'd9);
        next_cycle(); set_idle(); branch_taken = 1;
        @(negedge clk);
        total++; if (b_ifid_flush !== 1'b1 || b_pc_write !== 1'b1) begin
            bad++; $display("FAIL flush_in_ldstall flush=%b pc_write=%b want 1 1", b_ifid_flush, b_pc_write);
        end
        next_cycle(); set_idle();
        @(negedge clk);
        total++; if (b_pc_write !== 1'b1 || b_stall_cycles !== 4'd1) begin
            bad++; $display("FAIL flush_after_ldstall pc_write=%b cnt=%0d want 1 1", b_pc_write, b_stall_cycles);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        next_cycle(); set_load_use(5'd4);
        next_cycle(); set_idle();
        @(negedge clk);
        total++; if (b_pc_write !== 1'b0) begin
            bad++; $display("FAIL midrst_in_stall pc_write=%b want 0", b_pc_write);
        end
        next_cycle(); rst_n = 0;
        next_cycle(); rst_n = 1;
        @(negedge clk);
        total++; if (b_pc_write !== 1'b1 || b_stall_cycles !== 4'd0) begin
            bad++; $display("FAIL midrst_release pc_write=%b cnt=%0d want 1 0", b_pc_write, b_stall_cycles);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            next_cycle(); dmem_busy = 1;
        end
        next_cycle(); set_idle();
        @(negedge clk);
        total++; if (b_stall_cycles !== 4'd15) begin
            bad++; $display("FAIL sat_cnt4 got=%0d want=15", b_stall_cycles);
        end
        total++; if (a_stall_cycles !== 16'd20) begin
            bad++; $display("FAIL sat_cnt16 got=%0d want=20", a_stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [5:0] ea, eb;
        logic [3:0] ef;
        do_reset();
        rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            rst_n           = ($urandom_range(0, 49) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom);
            id_rs2_used     = 1'($urandom);
            idex_rs1        = 5'($urandom_range(0, 3));
            idex_rs2        = 5'($urandom_range(0, 3));
            idex_rd         = 5'($urandom_range(0, 3));
            idex_mem_read   = 1'($urandom);
            idex_reg_write  = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom);
            exmem_mem_read  = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_reg_write = 1'($urandom);
            branch_taken    = ($urandom_range(0, 7) == 0);
            dmem_busy       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            ea = model_ctl(rem_a);
            eb = model_ctl(rem_b);
            ef = {fwd_model(idex_rs1), fwd_model(idex_rs2)};
            total++; if ({a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_stall} !== ea) begin
                bad++; $display("FAIL rand_ctl_a cyc=%0d got=%b want=%b", i, {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_hold, a_stall}, ea);
            end
            total++; if ({b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_exmem_hold, b_stall} !== eb) begin
                bad++; $display("FAIL rand_ctl_b cyc=%0d got=%b want=%b", i, {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_exmem_hold, b_stall}, eb);
            end
            total++; if ({a_fwd_a, a_fwd_b} !== ef || {b_fwd_a, b_fwd_b} !== ef) begin
                bad++; $display("FAIL rand_fwd cyc=%0d a=%b b=%b want=%b", i, {a_fwd_a, a_fwd_b}, {b_fwd_a, b_fwd_b}, ef);
            end
            total++; if (a_stall_cycles !== 16'(cnt_a) || b_stall_cycles !== 4'(cnt_b)) begin
                bad++; $display("FAIL rand_cnt cyc=%0d a=%0d b=%0d want %0d %0d", i, a_stall_cycles, b_stall_cycles, cnt_a, cnt_b);
            end
            model_next(1, 65535, ea[0], rem_a, cnt_a);
            model_next(3, 15, eb[0], rem_b, cnt_b);
        end
        rst_n = 1;
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3_freeze();
        test_x0();
        test_forward();
        test_branch_flush();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline, sitting beside the ID/EX boundary and driving the PC, IF/ID and ID/EX control inputs. It generalises plain load-use detection:
- multi-cycle load-use stalls with a configurable load latency;
- EX-stage forwarding selects;
- branch-taken flush;
- a global freeze while data memory is busy;
- a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LATENCY, 1, stall cycles per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock. One clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  source is actually read (e.g. LUI reads neither).
- idex_rs1, idex_rs2  in  REG_ADDR_W  source registers of the instruction in EX.
- idex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- idex_mem_read, idex_reg_write  in  1  EX instruction is a load / writes a register.
- exmem_rd  in  REG_ADDR_W  destination register in MEM; exmem_reg_write, exmem_mem_read  in  1.
- memwb_rd  in  REG_ADDR_W  destination register in WB; memwb_reg_write  in  1.
- branch_taken  in  1  branch or jump resolved taken in EX.
- dmem_busy  in  1  data memory has not completed this cycle.
- pc_write, ifid_write  out  1  enable PC / IF-ID register update.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  zero the ID/EX control fields.
- exmem_hold  out  1  hold the EX/MEM and MEM/WB registers.
- fwd_a, fwd_b  out  2  ALU operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall  out  1  OR of all stall causes.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- Register x0 never creates a hazard and is never forwarded.
- Load-use hazard (`lu`): idex_mem_read and idex_rd≠0 and ((id_rs1_used and idex_rd==id_rs1) or (id_rs2_used and idex_rd==id_rs2)).
- FSM states RUN and LD_STALL, plus a 3-bit down-counter `cnt`.
  - RUN → LD_STALL when lu and LOAD_LATENCY>1 and no flush/freeze; cnt ← LOAD_LATENCY-1.
  - In LD_STALL, cnt decrements each non-frozen cycle. The state returns to RUN in the cycle after cnt reaches 1.
- Stall cycle, i.e. lu in RUN, or state LD_STALL: pc_write=0, ifid_write=0, idex_bubble=1.
- Freeze (dmem_busy=1): pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0. The FSM and cnt hold their values.
- Flush (branch_taken=1 and dmem_busy=0): ifid_flush=1, idex_bubble=1, pc_write=1. The FSM is forced to RUN and cnt is cleared.
- Priority: freeze > flush > load-use stall.
- Forwarding for operand A:
  - fwd_a=10 if exmem_reg_write, exmem_rd≠0, exmem_rd==idex_rs1 and not exmem_mem_read.
  - Otherwise fwd_a=01 if memwb_reg_write, memwb_rd≠0 and memwb_rd==idex_rs1.
  - Otherwise fwd_a=00.
- fwd_b is identical to fwd_a, using idex_rs2.
- stall = ~pc_write | exmem_hold.
- stall_cycles increments on every cycle where stall=1 and saturates at all-ones.

## Timing
- Reset values: state RUN, cnt=0, stall_cycles=0. Outputs during reset and in the cycle after: pc_write=1, ifid_write=1, all other outputs 0.
- Hazard, flush and forwarding outputs are combinational from the inputs and current state. There is zero-cycle latency to the pipeline enables.
- A load-use hazard produces exactly LOAD_LATENCY consecutive stalled cycles, excluding any freeze cycles inserted in between.
- branch_taken in a stalled cycle overrides the stall in that same cycle. The remaining stall cycles are dropped.
- rst_n low mid-stall returns the block to RUN on the next edge. The counter and stall_cycles clear.
- stall_cycles updates one cycle after the stalled cycle.

## Structure
- Shared package `pipe_pkg`: fwd_sel_t encoding (FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10) and the hz_state_t enum (RUN, LD_STALL).
- One sub-module, `forward_sel`, instantiated twice (operands A and B).
- The FSM, counter and priority logic live in the top module.

## Test plan
- LOAD_LATENCY=1, load x5 in EX, ID reads x5 → one cycle with pc_write=0 and idex_bubble=1. The next cycle returns to pc_write=1. stall_cycles=1.
- LOAD_LATENCY=3, same hazard → exactly 3 stalled cycles. dmem_busy=1 injected in the 2nd cycle extends the sequence to 4 cycles, with exmem_hold=1 only in the injected cycle.
- Load to x0, ID reads x0 → no stall. exmem_rd=x0 with exmem_reg_write=1 → fwd_a=00.
- EX/MEM and MEM/WB both write x7, idex_rs1=x7 → fwd_a=10. With exmem_mem_read=1 instead → fwd_a=01.
- branch_taken=1 in the 1st cycle of a LOAD_LATENCY=3 stall → ifid_flush=1, pc_write=1. The FSM returns to RUN and no further stall cycles occur.
- rst_n=0 for one cycle mid LD_STALL → next cycle pc_write=1, stall_cycles=0. Separately, force CNT_W=4 and hold a stall for 20 cycles → stall_cycles saturates at 15.
